// File: rtl/reg_read_sb_pkg.sv
// Shared sizing constants and helpers for the register-read/scoreboard block.
package reg_read_sb_pkg;

    localparam int N_DEF    = 16;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;
    localparam int CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    // Pending count as seen this cycle: a writeback retiring this register
    // frees one slot, but a count already at zero stays at zero.
    function automatic logic [CNT_W-1:0] eff_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic             wb_hit);
        return (wb_hit && (cnt != '0)) ? cnt - 1'b1 : cnt;
    endfunction

endpackage

// File: rtl/reg_read_sb_sb_cnt.sv
// One 2-bit pending-write counter. A decrement on an empty counter is ignored
// and reported on o_underflow; an increment at CNT_MAX is held off by stall.
module sb_cnt
    import reg_read_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_cnt;

    assign o_cnt       = r_cnt;
    assign o_underflow = i_dec && (r_cnt == '0);

    // Up/down count; simultaneous inc and dec cancel unless the dec underflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end else if (!i_inc && i_dec) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end else if (i_inc && i_dec && (r_cnt == '0)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reg_read_sb.sv
// Register file with write-before-read bypass and a per-register pending-write
// scoreboard that stalls issue on RAW hazards and on counter saturation.
module reg_read_sb
    import reg_read_sb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en1,
    input  logic             rd_en2,
    input  logic [IDX_W-1:0] rd_addr1,
    input  logic [IDX_W-1:0] rd_addr2,
    output logic [N-1:0]     rd_data1,
    output logic [N-1:0]     rd_data2,
    input  logic             iss_valid,
    input  logic             iss_wr,
    input  logic [IDX_W-1:0] iss_dst,
    output logic             stall,
    input  logic             wb_en,
    input  logic [IDX_W-1:0] wb_addr,
    input  logic [N-1:0]     writebackData,
    output logic             err
);

    logic [N-1:0]        r_regs [NUM_REGS];
    logic [CNT_W-1:0]    w_cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] w_underflow;
    logic                w_stall;
    logic                w_accept;
    logic                r_err;

    // Register array write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (wb_en) begin
            r_regs[wb_addr] <= writebackData;
        end
    end

    // Read ports with same-cycle writeback bypass.
    always_comb begin
        rd_data1 = r_regs[rd_addr1];
        rd_data2 = r_regs[rd_addr2];
        if (wb_en && (wb_addr == rd_addr1)) rd_data1 = writebackData;
        if (wb_en && (wb_addr == rd_addr2)) rd_data2 = writebackData;
    end

    // Stall on pending source operands or a saturated destination counter.
    always_comb begin
        w_stall = 1'b0;
        if (iss_valid) begin
            if (rd_en1 && (eff_cnt(w_cnt[rd_addr1], wb_en && (wb_addr == rd_addr1)) != '0))
                w_stall = 1'b1;
            if (rd_en2 && (eff_cnt(w_cnt[rd_addr2], wb_en && (wb_addr == rd_addr2)) != '0))
                w_stall = 1'b1;
            if (iss_wr && (eff_cnt(w_cnt[iss_dst], wb_en && (wb_addr == iss_dst)) == CNT_MAX))
                w_stall = 1'b1;
        end
    end

    assign stall    = w_stall;
    assign w_accept = iss_valid && !w_stall;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sb_cnt u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_accept && iss_wr && (iss_dst == IDX_W'(g))),
            .i_dec       (wb_en && (wb_addr == IDX_W'(g))),
            .o_cnt       (w_cnt[g]),
            .o_underflow (w_underflow[g])
        );
    end

    // Sticky error: writeback with nothing pending, or unknown control inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((|w_underflow) || $isunknown({iss_valid, wb_en})) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_reg_read_sb.sv
module tb_reg_read_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en1 = 1'b0, rd_en2 = 1'b0;
    logic [2:0]  rd_addr1 = '0, rd_addr2 = '0;
    logic [15:0] rd_data1, rd_data2;
    logic        iss_valid = 1'b0, iss_wr = 1'b0;
    logic [2:0]  iss_dst = '0;
    logic        stall;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] writebackData = '0;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    reg_read_sb #(.N(16)) dut (
        .clk(clk), .rst(rst),
        .rd_en1(rd_en1), .rd_en2(rd_en2),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dst(iss_dst),
        .stall(stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .writebackData(writebackData),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register values, pending counts, sticky error.
    logic [15:0] m_reg [8];
    int          m_cnt [8];
    bit          m_err;

    initial begin
        for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
        m_err = 1'b0;
    end

    function automatic int m_eff(input logic [2:0] r);
        if (wb_en && wb_addr == r && m_cnt[r] > 0) return m_cnt[r] - 1;
        return m_cnt[r];
    endfunction

    function automatic logic m_stall();
        if (!iss_valid) return 1'b0;
        return (rd_en1 && m_eff(rd_addr1) != 0) || (rd_en2 && m_eff(rd_addr2) != 0) ||
               (iss_wr && m_eff(iss_dst) == 3);
    endfunction

    function automatic logic [15:0] m_rd(input logic [2:0] a);
        if (wb_en && wb_addr == a) return writebackData;
        return m_reg[a];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
            m_err = 1'b0;
        end else begin
            bit acc;
            acc = iss_valid && iss_wr && !m_stall();
            if (wb_en) begin
                m_reg[wb_addr] = writebackData;
                if (m_cnt[wb_addr] == 0) m_err = 1'b1;
                else m_cnt[wb_addr]--;
            end
            if (acc) m_cnt[iss_dst]++;
        end
    end

    always @(negedge clk) begin
        chk("cyc_rd1",   rd_data1, m_rd(rd_addr1));
        chk("cyc_rd2",   rd_data2, m_rd(rd_addr2));
        chk("cyc_stall", stall,    m_stall());
        chk("cyc_err",   err,      m_err);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en1 = 0; rd_en2 = 0; iss_valid = 0; iss_wr = 0; wb_en = 0;
    endtask

    initial begin
        repeat (2) step();
        #1 rst = 1'b1;

        // Reset contents on both ports
        for (int a = 0; a < 8; a++) begin
            step();
            rd_addr1 = 3'(a); rd_addr2 = 3'(7 - a);
            #1;
            chk("rst_rd1", rd_data1, 16'h0000);
            chk("rst_rd2", rd_data2, 16'h0000);
        end
        chk("rst_stall", stall, 1'b0);
        chk("rst_err", err, 1'b0);

        // RAW hazard on r5 cleared by bypassed writeback
        step(); iss_valid = 1; iss_wr = 1; iss_dst = 5; #1;
        chk("iss5_acc", stall, 1'b0);
        step(); iss_wr = 0; rd_en1 = 1; rd_addr1 = 5; #1;
        chk("raw5_stall", stall, 1'b1);
        step(); wb_en = 1; wb_addr = 5; writebackData = 16'h1234; #1;
        chk("raw5_clear", stall, 1'b0);
        chk("raw5_bypass", rd_data1, 16'h1234);
        step(); idle();

        // Saturation of r2
        for (int k = 0; k < 3; k++) begin
            step(); iss_valid = 1; iss_wr = 1; iss_dst = 2; #1;
            chk("sat2_acc", stall, 1'b0);
        end
        step(); #1;
        chk("sat2_full", stall, 1'b1);
        wb_en = 1; wb_addr = 2; writebackData = 16'h2222; #1;
        chk("sat2_wb_relief", stall, 1'b0);
        step(); wb_en = 0; #1;
        chk("sat2_still3", stall, 1'b1);
        idle();
        for (int k = 0; k < 3; k++) begin
            step(); wb_en = 1; wb_addr = 2; writebackData = 16'(16'h2300 + k);
        end
        step(); idle(); #1;
        chk("drain_noerr", err, 1'b0);

        // Writeback with nothing pending
        step(); wb_en = 1; wb_addr = 6; writebackData = 16'h6666; #1;
        chk("uf6_pre", err, 1'b0);
        step(); wb_en = 0; rd_addr2 = 6; #1;
        chk("uf6_err", err, 1'b1);
        chk("uf6_wr", rd_data2, 16'h6666);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("uf6_sticky", err, 1'b1);
        end

        // Bypass then stored value on r3
        step(); wb_en = 1; wb_addr = 3; writebackData = 16'hBEEF; rd_addr1 = 3; #1;
        chk("byp3_same", rd_data1, 16'hBEEF);
        step(); wb_en = 0; #1;
        chk("byp3_next", rd_data1, 16'hBEEF);

        // Mid-cycle reset discards pending counts
        step(); iss_valid = 1; iss_wr = 1; iss_dst = 1;
        step();
        step(); iss_wr = 0; rd_en1 = 1; rd_addr1 = 1; rd_addr2 = 3; #1;
        chk("r1_pend", stall, 1'b1);
        #2 rst = 1'b0; #1;
        chk("arst_stall", stall, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_reg3", rd_data2, 16'h0000);
        step(); #1;
        chk("arst_hold", stall, 1'b0);
        #2 rst = 1'b1;
        step(); #1;
        chk("post_rst_stall", stall, 1'b0);
        idle();
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_read_sb.md
REG_READ_SB -- requirements
Module: reg_read_sb

Interface
REQ-001 Parameter N, default 16, data width of every register and data port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rd_en1, rd_en2  input  1 each  read port 1 and read port 2 operand used by the issuing instruction.
REQ-005 rd_addr1, rd_addr2  input  3 each  source register indices.
REQ-006 rd_data1, rd_data2  output  N each  source operand values.
REQ-007 iss_valid  input  1  decode presents an instruction this cycle.
REQ-008 iss_wr  input  1  presented instruction writes a register.
REQ-009 iss_dst  input  3  destination index of presented instruction.
REQ-010 stall  output  1  presented instruction is not accepted this cycle.
REQ-011 wb_en  input  1  writeback stage writes a register this cycle.
REQ-012 wb_addr  input  3  writeback destination index.
REQ-013 writebackData  input  N  value written by the writeback stage.
REQ-014 err  output  1  sticky protocol-violation flag.

Function
REQ-015 Storage: 8 registers of N bits; a write takes effect at the rising clk edge when wb_en=1, register wb_addr <= writebackData.
REQ-016 Reads: combinational, zero latency; rd_dataK = writebackData when wb_en=1 and wb_addr=rd_addrK, otherwise the stored register value (write-before-read bypass).
REQ-017 Scoreboard: one 2-bit pending-write counter per register, range 0..3.
REQ-018 Effective pending count for register r: cnt[r] minus 1 when wb_en=1 and wb_addr=r, otherwise cnt[r].
REQ-019 stall = iss_valid AND (any of: rd_en1 with effective count of rd_addr1 nonzero; rd_en2 with effective count of rd_addr2 nonzero; iss_wr with effective count of iss_dst equal to 3).
REQ-020 Issue accepted when iss_valid=1 and stall=0; when iss_wr=1, cnt[iss_dst] increments at that edge.
REQ-021 wb_en=1 decrements cnt[wb_addr] at the edge.
REQ-022 Accepted issue and writeback on the same register in the same cycle leave its count unchanged.
REQ-023 stall=0 whenever iss_valid=0; rd_en and iss_wr are ignored when iss_valid=0.
REQ-024 wb_en=1 to a register whose count is 0: count stays 0, register is still written, err set.
REQ-025 Counts never wrap: saturation at 3 is prevented by REQ-019; no accepted issue may exceed 3.
REQ-026 err, once set, stays 1 until reset; err also sets on any X/Z sampled on iss_valid or wb_en.

Reset
REQ-027 While rst=0: all 8 registers 0, all counts 0, err 0; stall and rd_data reflect that state combinationally.
REQ-028 rst assertion mid-operation discards all pending counts immediately; no write occurs on an edge while rst=0.
REQ-029 First state update occurs at the first rising clk edge after rst deasserts.

Structure
REQ-030 Shared package holds N default (16), register count (8), index width (3), count width (2), and the count-max constant (3).
REQ-031 One sub-module, sb_cnt: a single 2-bit up/down pending counter with inc, dec, and underflow flag; instantiated 8 times.
REQ-032 Register array, bypass muxes, and stall logic live in reg_read_sb.

Verification
REQ-033 Reset then read r0..r7 on both ports -> all 0x0000, stall=0, err=0.
REQ-034 wb_en=1, wb_addr=3, writebackData=0xBEEF, rd_addr1=3 same cycle -> rd_data1=0xBEEF same cycle; next cycle with wb_en=0 -> rd_data1=0xBEEF.
REQ-035 Issue iss_wr=1 iss_dst=5; next cycle rd_en1=1 rd_addr1=5 -> stall=1; cycle where wb_en=1 wb_addr=5 data=0x1234 -> stall=0, rd_data1=0x1234.
REQ-036 Three accepted issues to r2 with no writeback, fourth issue to r2 -> stall=1; one wb to r2 same cycle as fourth issue -> stall=0, count stays 3.
REQ-037 wb_en=1 wb_addr=6 with count 0 -> err=1, register 6 updated, err stays 1 for all later cycles until rst=0.
REQ-038 Two pending writes to r1, assert rst=0 between edges -> stall drops immediately, counts 0, registers 0.
